// File: rtl/sc_metadata_table.sv
// Per-lane note-time store: head register plus small FIFO per lane, presented
// to the note matcher with consume, auto-expiry (miss) and flush.
module sc_metadata_table #(
   parameter int unsigned    NLANES      = 37,
   parameter int unsigned    TW          = 16,
   parameter int unsigned    DEPTH       = 4,
   parameter logic [TW-1:0]  MISS_WINDOW = 16'd200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pause,
   input  logic                 flush,
   input  logic [TW-1:0]        song_time,
   input  logic                 load_valid,
   input  logic [5:0]           load_lane,
   input  logic [TW-1:0]        load_time,
   output logic                 load_ready,
   input  logic [NLANES-1:0]    metadata_request,
   output logic [NLANES*TW-1:0] metadata_link,
   output logic [NLANES-1:0]    metadata_available,
   output logic [NLANES-1:0]    miss
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [TW-1:0]     head_time [NLANES];
   logic [NLANES-1:0] head_valid;
   logic [CW-1:0]     cnt       [NLANES];
   logic [PW-1:0]     rd_ptr    [NLANES];
   logic [PW-1:0]     wr_ptr    [NLANES];
   logic [TW-1:0]     mem       [NLANES][DEPTH];

   logic [NLANES-1:0] full, consume, expire, pop, fifo_pop, load_hit, to_head, push;
   logic              lane_oob;
   logic              sel_full;

   // Loader handshake: out-of-range lanes are always accepted and discarded
   always_comb begin
      lane_oob = 32'(load_lane) >= NLANES;
      sel_full = 1'b0;
      for (int i = 0; i < int'(NLANES); i++) begin
         if (load_lane == 6'(i)) sel_full = full[i];
      end
      load_ready = lane_oob | ~sel_full;
   end

   // Per-lane event decode; a consume never frees space for the same cycle's load
   always_comb begin
      full          = '0;
      consume       = '0;
      expire        = '0;
      pop           = '0;
      fifo_pop      = '0;
      load_hit      = '0;
      to_head       = '0;
      push          = '0;
      metadata_link = '0;
      for (int i = 0; i < int'(NLANES); i++) begin
         full[i]     = head_valid[i] & (cnt[i] == CW'(DEPTH));
         consume[i]  = metadata_request[i] & head_valid[i];
         expire[i]   = ~pause & head_valid[i] &
                       ({1'b0, song_time} > ({1'b0, head_time[i]} + {1'b0, MISS_WINDOW}));
         pop[i]      = consume[i] | expire[i];
         fifo_pop[i] = pop[i] & (cnt[i] != '0);
         load_hit[i] = load_valid & ~flush & ~lane_oob & ~full[i] & (load_lane == 6'(i));
         to_head[i]  = load_hit[i] & (~head_valid[i] | (pop[i] & (cnt[i] == '0)));
         push[i]     = load_hit[i] & ~to_head[i];
         metadata_link[i*TW +: TW] = head_time[i];
      end
   end

   assign metadata_available = head_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_valid <= '0;
         miss       <= '0;
         for (int i = 0; i < int'(NLANES); i++) begin
            head_time[i] <= '0;
            cnt[i]       <= '0;
            rd_ptr[i]    <= '0;
            wr_ptr[i]    <= '0;
         end
      end else if (flush) begin
         head_valid <= '0;
         miss       <= '0;
         for (int i = 0; i < int'(NLANES); i++) begin
            head_time[i] <= '0;
            cnt[i]       <= '0;
            rd_ptr[i]    <= '0;
            wr_ptr[i]    <= '0;
         end
      end else begin
         // A request beats a same-cycle expiry, so no miss is reported then
         miss <= expire & ~consume;
         for (int i = 0; i < int'(NLANES); i++) begin
            if (fifo_pop[i]) begin
               head_time[i] <= mem[i][rd_ptr[i]];
               rd_ptr[i]    <= rd_ptr[i] + PW'(1);
            end else if (to_head[i]) begin
               head_time[i]  <= load_time;
               head_valid[i] <= 1'b1;
            end else if (pop[i]) begin
               head_valid[i] <= 1'b0;
            end
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            cnt[i] <= cnt[i] + CW'(push[i]) - CW'(fifo_pop[i]);
         end
      end
   end

   // FIFO storage needs no reset; validity is tracked by the counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NLANES); i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= load_time;
      end
   end

endmodule

// File: tb/tb_sc_metadata_table.sv
// Directed self-checking bench for sc_metadata_table.
module tb_sc_metadata_table;

   localparam int unsigned NLANES = 37;
   localparam int unsigned TW     = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 pause;
   logic                 flush;
   logic [TW-1:0]        song_time;
   logic                 load_valid;
   logic [5:0]           load_lane;
   logic [TW-1:0]        load_time;
   logic                 load_ready;
   logic [NLANES-1:0]    metadata_request;
   logic [NLANES*TW-1:0] metadata_link;
   logic [NLANES-1:0]    metadata_available;
   logic [NLANES-1:0]    miss;

   int total = 0;
   int bad   = 0;

   sc_metadata_table dut (
      .clk                (clk),
      .reset              (reset),
      .pause              (pause),
      .flush              (flush),
      .song_time          (song_time),
      .load_valid         (load_valid),
      .load_lane          (load_lane),
      .load_time          (load_time),
      .load_ready         (load_ready),
      .metadata_request   (metadata_request),
      .metadata_link      (metadata_link),
      .metadata_available (metadata_available),
      .miss               (miss)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [TW-1:0] lk(input int i);
      return metadata_link[i*TW +: TW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int lane, input int t);
      load_valid = 1'b1;
      load_lane  = 6'(lane);
      load_time  = TW'(t);
      tick();
      load_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pause = 1'b0; flush = 1'b0; song_time = '0;
      load_valid = 1'b0; load_lane = '0; load_time = '0; metadata_request = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_avail", 64'(metadata_available), 64'd0);
      check("rst_link_zero", 64'(metadata_link == '0), 64'd1);
      check("rst_miss", 64'(miss), 64'd0);
      reset = 1'b0;

      // Single load into lane 3
      load_valid = 1'b1; load_lane = 6'd3; load_time = 16'd1000;
      #1 check("load3_ready", 64'(load_ready), 64'd1);
      tick();
      load_valid = 1'b0;
      check("load3_avail", 64'(metadata_available), 64'd1 << 3);
      check("load3_link", 64'(lk(3)), 64'd1000);

      // Fill lane 0 then backpressure
      for (int k = 1; k <= 5; k++) load(0, 10 * k);
      load_valid = 1'b1; load_lane = 6'd0; load_time = 16'd60;
      #1 check("full_ready", 64'(load_ready), 64'd0);
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("fifo_link", 64'(lk(0)), 64'(10 * (k + 1)));
         check("fifo_avail", 64'(metadata_available[0]), 64'd1);
         metadata_request[0] = 1'b1;
         tick();
      end
      metadata_request = '0;
      check("fifo_drained", 64'(metadata_available[0]), 64'd0);

      // Same-cycle load and consume on a head-only lane
      load(5, 100);
      check("l5_head", 64'(lk(5)), 64'd100);
      metadata_request[5] = 1'b1;
      load_valid = 1'b1; load_lane = 6'd5; load_time = 16'd200;
      #1 check("l5_ready", 64'(load_ready), 64'd1);
      tick();
      metadata_request = '0; load_valid = 1'b0;
      check("l5_avail", 64'(metadata_available[5]), 64'd1);
      check("l5_link", 64'(lk(5)), 64'd200);

      // Out-of-range lane is accepted and dropped
      load_valid = 1'b1; load_lane = 6'd40; load_time = 16'd77;
      #1 check("oob_ready", 64'(load_ready), 64'd1);
      tick();
      load_valid = 1'b0;
      check("oob_avail", 64'(metadata_available), (64'd1 << 3) | (64'd1 << 5));

      // Flush with a coincident load that must be dropped
      flush = 1'b1; load_valid = 1'b1; load_lane = 6'd1; load_time = 16'd55;
      tick();
      flush = 1'b0; load_valid = 1'b0;
      check("flush_avail", 64'(metadata_available), 64'd0);
      check("flush_link_zero", 64'(metadata_link == '0), 64'd1);
      load(1, 42);
      check("post_flush_avail", 64'(metadata_available), 64'd1 << 1);
      check("post_flush_link", 64'(lk(1)), 64'd42);

      // Request on an empty lane is ignored
      metadata_request[2] = 1'b1;
      tick();
      metadata_request = '0;
      check("ign_avail", 64'(metadata_available), 64'd1 << 1);
      check("ign_miss", 64'(miss), 64'd0);
      load(2, 321);
      check("ign_load_avail", 64'(metadata_available[2]), 64'd1);
      check("ign_load_link", 64'(lk(2)), 64'd321);

      // Expiry on lane 7 from a clean table
      flush = 1'b1;
      tick();
      flush = 1'b0;
      load(7, 500); load(7, 550); load(7, 600);
      song_time = 16'd700;
      tick();
      check("exp700_miss", 64'(miss[7]), 64'd0);
      check("exp700_link", 64'(lk(7)), 64'd500);
      song_time = 16'd701;
      tick();
      check("exp701_miss", 64'(miss[7]), 64'd1);
      check("exp701_link", 64'(lk(7)), 64'd550);
      check("exp701_avail", 64'(metadata_available[7]), 64'd1);
      tick();
      check("miss_one_cycle", 64'(miss[7]), 64'd0);
      pause = 1'b1; song_time = 16'd800;
      tick();
      check("pause_miss", 64'(miss), 64'd0);
      check("pause_link", 64'(lk(7)), 64'd550);
      pause = 1'b0; metadata_request[7] = 1'b1;
      tick();
      metadata_request = '0;
      check("req_vs_exp_miss", 64'(miss[7]), 64'd0);
      check("req_vs_exp_link", 64'(lk(7)), 64'd600);
      song_time = '0;

      // Asynchronous mid-operation reset
      load(4, 1234);
      reset = 1'b1;
      #1;
      check("async_rst_avail", 64'(metadata_available), 64'd0);
      check("async_rst_link", 64'(lk(7)), 64'd0);
      tick();
      reset = 1'b0;
      load(4, 99);
      check("after_rst_link", 64'(lk(4)), 64'd99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
